mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Y86-64 memory stage: M pipeline register plus a request/ack data-memory
// bus master with address check, bus-error and timeout reporting.
module mem_stage #(
  parameter logic [63:0] MEM_LIMIT = 64'h0000_0000_0000_2000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  E_icode_i,
  input  logic [2:0]  E_stat_i,
  input  logic        e_Cnd_i,
  input  logic [63:0] e_valE_i,
  input  logic [63:0] E_valA_i,
  input  logic [3:0]  e_dstE_i,
  input  logic [3:0]  e_dstM_i,
  input  logic        M_bubble_i,
  output logic [3:0]  M_icode_o,
  output logic [2:0]  M_stat_o,
  output logic        M_Cnd_o,
  output logic [63:0] M_valE_o,
  output logic [63:0] M_valA_o,
  output logic [3:0]  M_dstE_o,
  output logic [3:0]  M_dstM_o,
  output logic [63:0] m_valM_o,
  output logic [2:0]  m_stat_o,
  output logic        m_stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [63:0] dmem_addr_o,
  output logic [63:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic        dmem_err_i,
  input  logic [63:0] dmem_rdata_i
);

  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [2:0] SAOK    = 3'd1;
  localparam logic [2:0] SADR    = 3'd3;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Pipeline register and stage state
  logic [3:0]       icode_q, icode_d;
  logic [2:0]       stat_q, stat_d;
  logic             cnd_q, cnd_d;
  logic [63:0]      vale_q, vale_d;
  logic [63:0]      vala_q, vala_d;
  logic [3:0]       dste_q, dste_d;
  logic [3:0]       dstm_q, dstm_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [63:0]      valm_q, valm_d;
  logic [2:0]       mstat_q, mstat_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic             is_rd_q, is_rd_d;
  logic [63:0]      addr_q, addr_d;

  // Incoming instruction (execute results or bubble)
  logic [3:0]  in_icode;
  logic [2:0]  in_stat;
  logic        in_cnd;
  logic [63:0] in_vale;
  logic [63:0] in_vala;
  logic [3:0]  in_dste;
  logic [3:0]  in_dstm;
  logic        in_rd;
  logic        in_wr;
  logic        in_mem;
  logic [63:0] in_addr;
  logic        in_bad;
  logic        in_go;

  always_comb begin
    in_icode = E_icode_i;
    in_stat  = E_stat_i;
    in_cnd   = e_Cnd_i;
    in_vale  = e_valE_i;
    in_vala  = E_valA_i;
    in_dste  = e_dstE_i;
    in_dstm  = e_dstM_i;
    if (M_bubble_i) begin
      in_icode = INOP;
      in_stat  = SAOK;
      in_cnd   = 1'b0;
      in_vale  = 64'd0;
      in_vala  = 64'd0;
      in_dste  = RNONE;
      in_dstm  = RNONE;
    end
    in_rd   = (in_icode == IMRMOVQ) || (in_icode == IPOPQ) || (in_icode == IRET);
    in_wr   = (in_icode == IRMMOVQ) || (in_icode == IPUSHQ) || (in_icode == ICALL);
    in_mem  = in_rd || in_wr;
    in_addr = ((in_icode == IPOPQ) || (in_icode == IRET)) ? in_vala : in_vale;
    in_bad  = in_mem && (in_stat == SAOK) && (in_addr >= MEM_LIMIT);
    in_go   = in_mem && (in_stat == SAOK) && !in_bad;
  end

  // Next-state: hold in ACCESS until ack/err/timeout, otherwise load M
  always_comb begin
    icode_d = icode_q;
    stat_d  = stat_q;
    cnd_d   = cnd_q;
    vale_d  = vale_q;
    vala_d  = vala_q;
    dste_d  = dste_q;
    dstm_d  = dstm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    valm_d  = valm_q;
    mstat_d = mstat_q;
    req_d   = req_q;
    we_d    = we_q;
    is_rd_d = is_rd_q;
    addr_d  = addr_q;

    if (state_q == S_ACCESS) begin
      if (dmem_err_i) begin
        state_d = S_DONE;
        err_d   = 1'b1;
        mstat_d = SADR;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end else if (dmem_ack_i) begin
        state_d = S_DONE;
        req_d   = 1'b0;
        we_d    = 1'b0;
        if (is_rd_q) begin
          valm_d = dmem_rdata_i;
        end
      end else if (cnt_q == CNT_LAST) begin
        state_d = S_DONE;
        err_d   = 1'b1;
        mstat_d = SADR;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      icode_d = in_icode;
      stat_d  = in_stat;
      cnd_d   = in_cnd;
      vale_d  = in_vale;
      vala_d  = in_vala;
      dste_d  = in_dste;
      dstm_d  = in_dstm;
      state_d = in_go ? S_ACCESS : S_IDLE;
      cnt_d   = '0;
      err_d   = 1'b0;
      valm_d  = 64'd0;
      mstat_d = in_bad ? SADR : in_stat;
      req_d   = in_go;
      we_d    = in_go && in_wr;
      is_rd_d = in_rd;
      addr_d  = in_addr;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      icode_q <= INOP;
      stat_q  <= SAOK;
      cnd_q   <= 1'b0;
      vale_q  <= 64'd0;
      vala_q  <= 64'd0;
      dste_q  <= RNONE;
      dstm_q  <= RNONE;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      valm_q  <= 64'd0;
      mstat_q <= SAOK;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      is_rd_q <= 1'b0;
      addr_q  <= 64'd0;
    end else begin
      icode_q <= icode_d;
      stat_q  <= stat_d;
      cnd_q   <= cnd_d;
      vale_q  <= vale_d;
      vala_q  <= vala_d;
      dste_q  <= dste_d;
      dstm_q  <= dstm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      valm_q  <= valm_d;
      mstat_q <= mstat_d;
      req_q   <= req_d;
      we_q    <= we_d;
      is_rd_q <= is_rd_d;
      addr_q  <= addr_d;
    end
  end

  assign M_icode_o    = icode_q;
  assign M_stat_o     = stat_q;
  assign M_Cnd_o      = cnd_q;
  assign M_valE_o     = vale_q;
  assign M_valA_o     = vala_q;
  assign M_dstE_o     = dste_q;
  assign M_dstM_o     = dstm_q;
  assign m_valM_o     = valm_q;
  assign m_stat_o     = mstat_q;
  // req_q is set exactly while the FSM sits in ACCESS
  assign m_stall_o    = req_q;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = vala_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of single-instruction vectors with
// a responding bus model, plus hand sequences for bubble-hold and reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  E_icode_i;
  logic [2:0]  E_stat_i;
  logic        e_Cnd_i;
  logic [63:0] e_valE_i;
  logic [63:0] E_valA_i;
  logic [3:0]  e_dstE_i;
  logic [3:0]  e_dstM_i;
  logic        M_bubble_i;
  logic [3:0]  M_icode_o;
  logic [2:0]  M_stat_o;
  logic        M_Cnd_o;
  logic [63:0] M_valE_o;
  logic [63:0] M_valA_o;
  logic [3:0]  M_dstE_o;
  logic [3:0]  M_dstM_o;
  logic [63:0] m_valM_o;
  logic [2:0]  m_stat_o;
  logic        m_stall_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [63:0] dmem_addr_o;
  logic [63:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic        dmem_err_i;
  logic [63:0] dmem_rdata_i;

  mem_stage dut (
    .clk_i(clk), .rst_i(rst),
    .E_icode_i(E_icode_i), .E_stat_i(E_stat_i), .e_Cnd_i(e_Cnd_i),
    .e_valE_i(e_valE_i), .E_valA_i(E_valA_i), .e_dstE_i(e_dstE_i),
    .e_dstM_i(e_dstM_i), .M_bubble_i(M_bubble_i),
    .M_icode_o(M_icode_o), .M_stat_o(M_stat_o), .M_Cnd_o(M_Cnd_o),
    .M_valE_o(M_valE_o), .M_valA_o(M_valA_o), .M_dstE_o(M_dstE_o),
    .M_dstM_o(M_dstM_o), .m_valM_o(m_valM_o), .m_stat_o(m_stat_o),
    .m_stall_o(m_stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_err_i(dmem_err_i), .dmem_rdata_i(dmem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode;
    logic [2:0]  stat;
    logic [63:0] vale;
    logic [63:0] vala;
    int          ack_at;   // ACCESS cycle in which the bus responds, 0 = never
    logic        err;
    logic [63:0] rdata;
    int          exp_cyc;  // expected stall / request cycles
    logic        exp_we;
    logic [63:0] exp_addr;
    logic [2:0]  exp_stat;
    logic [63:0] exp_valm;
  } vec_t;

  localparam int NVEC = 12;
  vec_t tbl[NVEC];
  vec_t exp_q[$];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [2:0] st,
                       input logic [63:0] ve, input logic [63:0] va);
    E_icode_i  = ic;
    E_stat_i   = st;
    e_Cnd_i    = 1'b1;
    e_valE_i   = ve;
    E_valA_i   = va;
    e_dstE_i   = 4'h3;
    e_dstM_i   = 4'h5;
    M_bubble_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    int stall_cnt;
    int req_cnt;
    exp_q.push_back(v);
    drive(v.icode, v.stat, v.vale, v.vala);
    tick();
    M_bubble_i = 1'b1;
    chk("load_icode", 64'(M_icode_o), 64'(v.icode));
    stall_cnt = 0;
    req_cnt   = 0;
    while (m_stall_o && stall_cnt < 300) begin
      stall_cnt++;
      if (dmem_req_o) req_cnt++;
      if (stall_cnt == 1) begin
        chk("we", 64'(dmem_we_o), 64'(v.exp_we));
        chk("addr", dmem_addr_o, v.exp_addr);
        chk("wdata", dmem_wdata_o, v.vala);
      end
      if (stall_cnt == v.ack_at) begin
        dmem_ack_i   = 1'b1;
        dmem_err_i   = v.err;
        dmem_rdata_i = v.rdata;
      end
      tick();
      dmem_ack_i   = 1'b0;
      dmem_err_i   = 1'b0;
      dmem_rdata_i = {$urandom, $urandom};
    end
    e = exp_q.pop_front();
    chk("stall_cycles", 64'(stall_cnt), 64'(e.exp_cyc));
    chk("req_cycles", 64'(req_cnt), 64'(e.exp_cyc));
    chk("req_after", 64'(dmem_req_o), 64'd0);
    chk("m_stat", 64'(m_stat_o), 64'(e.exp_stat));
    chk("m_valM", m_valM_o, e.exp_valm);
  endtask

  initial begin
    //          icode  stat  valE                    valA           ack err rdata          cyc we addr                    stat  valM
    tbl[0]  = '{4'h5, 3'd1, 64'h100,                64'h0,          3, 1'b0, 64'hDEAD_BEEF, 3, 1'b0, 64'h100,               3'd1, 64'hDEAD_BEEF};
    tbl[1]  = '{4'hA, 3'd1, 64'h1F8,                64'h55,         1, 1'b0, 64'h0,         1, 1'b1, 64'h1F8,               3'd1, 64'h0};
    tbl[2]  = '{4'h4, 3'd1, 64'h2000,               64'h9,          0, 1'b0, 64'h0,         0, 1'b0, 64'h0,                 3'd3, 64'h0};
    tbl[3]  = '{4'hB, 3'd1, 64'h0,                  64'h40,         0, 1'b0, 64'h0,        16, 1'b0, 64'h40,                3'd3, 64'h0};
    tbl[4]  = '{4'h5, 3'd1, 64'h200,                64'h0,          2, 1'b1, 64'h1111,      2, 1'b0, 64'h200,               3'd3, 64'h0};
    tbl[5]  = '{4'h9, 3'd1, 64'h0,                  64'h1FF8,       1, 1'b0, 64'h1234,      1, 1'b0, 64'h1FF8,              3'd1, 64'h1234};
    tbl[6]  = '{4'h6, 3'd1, 64'h100,                64'h7,          0, 1'b0, 64'h0,         0, 1'b0, 64'h0,                 3'd1, 64'h0};
    tbl[7]  = '{4'h5, 3'd4, 64'h100,                64'h0,          0, 1'b0, 64'h0,         0, 1'b0, 64'h0,                 3'd4, 64'h0};
    tbl[8]  = '{4'h8, 3'd1, 64'h1FF8,               64'hABCD,       1, 1'b0, 64'h0,         1, 1'b1, 64'h1FF8,              3'd1, 64'h0};
    tbl[9]  = '{4'hB, 3'd1, 64'h0,                  64'h80,        16, 1'b0, 64'h77,       16, 1'b0, 64'h80,                3'd1, 64'h77};
    tbl[10] = '{4'h5, 3'd1, 64'h1FFF,               64'h0,          1, 1'b0, 64'h5,         1, 1'b0, 64'h1FFF,              3'd1, 64'h5};
    tbl[11] = '{4'h4, 3'd1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1,         0, 1'b0, 64'h0,         0, 1'b0, 64'h0,                 3'd3, 64'h0};

    rst          = 1'b1;
    dmem_ack_i   = 1'b0;
    dmem_err_i   = 1'b0;
    dmem_rdata_i = 64'h0;
    drive(4'h5, 3'd1, 64'h100, 64'h0);
    #1;
    chk("rst_icode", 64'(M_icode_o), 64'h1);
    chk("rst_dstE", 64'(M_dstE_o), 64'hF);
    chk("rst_dstM", 64'(M_dstM_o), 64'hF);
    chk("rst_stat", 64'(m_stat_o), 64'd1);
    chk("rst_req", 64'(dmem_req_o), 64'd0);
    chk("rst_stall", 64'(m_stall_o), 64'd0);
    chk("rst_valM", m_valM_o, 64'h0);
    tick();
    tick();
    chk("rst_hold_icode", 64'(M_icode_o), 64'h1);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      run_vec(tbl[i]);
    end

    // Bubble requested while stalled: M holds until ack, then the bubble loads
    drive(4'h5, 3'd1, 64'h100, 64'h0);
    tick();
    E_icode_i  = 4'h6;
    M_bubble_i = 1'b1;
    tick();
    tick();
    chk("bub_hold_icode", 64'(M_icode_o), 64'h5);
    chk("bub_hold_stall", 64'(m_stall_o), 64'd1);
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 64'hABC;
    tick();
    dmem_ack_i = 1'b0;
    chk("bub_done_icode", 64'(M_icode_o), 64'h5);
    chk("bub_done_valM", m_valM_o, 64'hABC);
    chk("bub_done_stall", 64'(m_stall_o), 64'd0);
    tick();
    chk("bub_load_icode", 64'(M_icode_o), 64'h1);
    chk("bub_load_dstE", 64'(M_dstE_o), 64'hF);
    chk("bub_load_dstM", 64'(M_dstM_o), 64'hF);
    chk("bub_load_valM", m_valM_o, 64'h0);

    // Reset asserted in the second ACCESS cycle
    drive(4'h5, 3'd1, 64'h100, 64'h0);
    tick();
    tick();
    chk("mid_stall", 64'(m_stall_o), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", 64'(dmem_req_o), 64'd0);
    chk("mid_rst_stall", 64'(m_stall_o), 64'd0);
    chk("mid_rst_icode", 64'(M_icode_o), 64'h1);
    chk("mid_rst_stat", 64'(m_stat_o), 64'd1);
    tick();
    rst = 1'b0;
    drive(4'h6, 3'd1, 64'h10, 64'h20);
    tick();
    chk("post_rst_icode", 64'(M_icode_o), 64'h6);
    chk("post_rst_valE", M_valE_o, 64'h10);
    chk("post_rst_stall", 64'(m_stall_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
